// File: rtl/matmul_operand_fetch_mult.sv
// Operand fetch and multiply stage: walks A and B in row-of-C order (k innermost),
// issues one read pair per cycle and emits a registered full-width product with aligned indices.
module matmul_operand_fetch_mult #(
    parameter int M                      = 4,
    parameter int K                      = 4,
    parameter int N                      = 4,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  matrix_a_re,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
    output logic                                  matrix_b_re,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr_counter_reg,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr_counter_reg,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr_counter_reg,
    output logic                                  mult_done_reg
);

    localparam int W  = DATA_WIDTH_INIT_MATRIX;
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);

    localparam logic [MW-1:0] I_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] J_LAST = NW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          issue;
    logic          last_issue;
    logic          drain_cnt;
    logic [MW-1:0] i_cnt;
    logic [NW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;

    logic          vld_p1;
    logic [MW-1:0] i_p1;
    logic [NW-1:0] j_p1;
    logic [KW-1:0] k_p1;

    function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    assign last_issue = (i_cnt == I_LAST) && (j_cnt == J_LAST) && (k_cnt == K_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        issue = (state == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // Stage 0: issue counters double as the read addresses (wrap at M-1/N-1/K-1, not 2^w-1)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (issue) begin
            k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
            if (k_cnt == K_LAST) begin
                j_cnt <= (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
                if (j_cnt == J_LAST) begin
                    i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
                end
            end
        end else begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end
    end

    assign matrix_a_re       = issue;
    assign matrix_b_re       = issue;
    assign matrix_a_row_addr = i_cnt;
    assign matrix_a_col_addr = k_cnt;
    assign matrix_b_row_addr = k_cnt;
    assign matrix_b_col_addr = j_cnt;

    // Stage 1: memory is returning data; indices and valid wait alongside it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            i_p1   <= '0;
            j_p1   <= '0;
            k_p1   <= '0;
        end else begin
            vld_p1 <= issue;
            i_p1   <= i_cnt;
            j_p1   <= j_cnt;
            k_p1   <= k_cnt;
        end
    end

    // Stage 2: registered product and aligned indices; hold last values when not valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mult_done_reg                 <= 1'b0;
            product_reg                   <= '0;
            matrix_a_row_addr_counter_reg <= '0;
            matrix_a_col_addr_counter_reg <= '0;
            matrix_b_row_addr_counter_reg <= '0;
            matrix_b_col_addr_counter_reg <= '0;
        end else begin
            mult_done_reg <= vld_p1;
            if (vld_p1) begin
                product_reg                   <= mul_full(data_in_a, data_in_b);
                matrix_a_row_addr_counter_reg <= i_p1;
                matrix_a_col_addr_counter_reg <= k_p1;
                matrix_b_row_addr_counter_reg <= k_p1;
                matrix_b_col_addr_counter_reg <= j_p1;
            end
        end
    end

endmodule

// File: tb/tb_matmul_operand_fetch_mult.sv
// Directed bench for matmul_operand_fetch_mult: 2x2x2, 4x4x4 and 3x3x2 instances with
// synchronous-read memory models in front of each.
module tb_matmul_operand_fetch_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // 2x2x2 instance
    logic        rstn2, start2, busy2, done2, are2, bre2, mdone2;
    logic [0:0]  arow2, acol2, brow2, bcol2, ai2, ak2, bj2, bk2;
    logic [31:0] da2, db2;
    logic [63:0] prod2;
    logic [31:0] A2 [2][2];
    logic [31:0] B2 [2][2];

    // 4x4x4 instance
    logic        rstn4, start4, busy4, done4, are4, bre4, mdone4;
    logic [1:0]  arow4, acol4, brow4, bcol4, ai4, ak4, bj4, bk4;
    logic [31:0] da4, db4;
    logic [63:0] prod4;
    logic [31:0] A4 [4][4];
    logic [31:0] B4 [4][4];

    // 3x3x2 instance
    logic        rstn3, start3, busy3, done3, are3, bre3, mdone3;
    logic [1:0]  arow3, acol3, brow3, ai3, ak3, bk3;
    logic [0:0]  bcol3, bj3;
    logic [31:0] da3, db3;
    logic [63:0] prod3;
    logic [31:0] A3 [3][3];
    logic [31:0] B3 [3][2];

    matmul_operand_fetch_mult #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) u2 (
        .clk(clk), .resetn(rstn2), .start(start2), .busy(busy2), .done(done2),
        .matrix_a_re(are2), .matrix_a_row_addr(arow2), .matrix_a_col_addr(acol2), .data_in_a(da2),
        .matrix_b_re(bre2), .matrix_b_row_addr(brow2), .matrix_b_col_addr(bcol2), .data_in_b(db2),
        .product_reg(prod2),
        .matrix_a_col_addr_counter_reg(ak2), .matrix_a_row_addr_counter_reg(ai2),
        .matrix_b_col_addr_counter_reg(bj2), .matrix_b_row_addr_counter_reg(bk2),
        .mult_done_reg(mdone2)
    );

    matmul_operand_fetch_mult #(.M(4), .K(4), .N(4), .DATA_WIDTH_INIT_MATRIX(32)) u4 (
        .clk(clk), .resetn(rstn4), .start(start4), .busy(busy4), .done(done4),
        .matrix_a_re(are4), .matrix_a_row_addr(arow4), .matrix_a_col_addr(acol4), .data_in_a(da4),
        .matrix_b_re(bre4), .matrix_b_row_addr(brow4), .matrix_b_col_addr(bcol4), .data_in_b(db4),
        .product_reg(prod4),
        .matrix_a_col_addr_counter_reg(ak4), .matrix_a_row_addr_counter_reg(ai4),
        .matrix_b_col_addr_counter_reg(bj4), .matrix_b_row_addr_counter_reg(bk4),
        .mult_done_reg(mdone4)
    );

    matmul_operand_fetch_mult #(.M(3), .K(3), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) u3 (
        .clk(clk), .resetn(rstn3), .start(start3), .busy(busy3), .done(done3),
        .matrix_a_re(are3), .matrix_a_row_addr(arow3), .matrix_a_col_addr(acol3), .data_in_a(da3),
        .matrix_b_re(bre3), .matrix_b_row_addr(brow3), .matrix_b_col_addr(bcol3), .data_in_b(db3),
        .product_reg(prod3),
        .matrix_a_col_addr_counter_reg(ak3), .matrix_a_row_addr_counter_reg(ai3),
        .matrix_b_col_addr_counter_reg(bj3), .matrix_b_row_addr_counter_reg(bk3),
        .mult_done_reg(mdone3)
    );

    // Synchronous-read memories: data one cycle after the read enable
    always @(posedge clk) begin
        if (are2) da2 <= A2[arow2][acol2];
        if (bre2) db2 <= B2[brow2][bcol2];
        if (are4) da4 <= A4[arow4][acol4];
        if (bre4) db4 <= B4[brow4][bcol4];
        if (are3) da3 <= A3[arow3][acol3];
        if (bre3) db3 <= B3[brow3][bcol3];
    end

    // Hand-computed results for A=[[1,2],[3,4]], B=[[5,6],[7,8]]; tuple is {i,j,k,k}
    logic [63:0] exp_p   [8];
    logic [3:0]  exp_idx [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        A2[0][0] = 32'd1; A2[0][1] = 32'd2; A2[1][0] = 32'd3; A2[1][1] = 32'd4;
        B2[0][0] = 32'd5; B2[0][1] = 32'd6; B2[1][0] = 32'd7; B2[1][1] = 32'd8;
    endtask

    task automatic test_reset();
        rstn2 = 1'b0; rstn4 = 1'b0; rstn3 = 1'b0;
        start2 = 1'b0; start4 = 1'b0; start3 = 1'b0;
        tick(); tick();
        n_vec++;
        if ({busy2, done2, are2, bre2, mdone2} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b exp 00000", {busy2, done2, are2, bre2, mdone2});
        end
        n_vec++;
        if (prod2 !== 64'd0) begin
            n_err++; $display("FAIL reset_prod got %h exp 0", prod2);
        end
        n_vec++;
        if ({ai2, bj2, ak2, bk2, arow2, acol2, brow2, bcol2} !== 8'b0) begin
            n_err++; $display("FAIL reset_idx got %b exp 0", {ai2, bj2, ak2, bk2, arow2, acol2, brow2, bcol2});
        end
        n_vec++;
        if ({busy4, mdone4, busy3, mdone3} !== 4'b0) begin
            n_err++; $display("FAIL reset_others got %b exp 0000", {busy4, mdone4, busy3, mdone3});
        end
        rstn2 = 1'b1; rstn4 = 1'b1; rstn3 = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic e_v;
        load_basic();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            e_v = (c >= 3 && c <= 10);
            n_vec++;
            if (mdone2 !== e_v) begin
                n_err++; $display("FAIL basic_valid c=%0d got %b exp %b", c, mdone2, e_v);
            end
            if (e_v) begin
                n_vec++;
                if (prod2 !== exp_p[c-3]) begin
                    n_err++; $display("FAIL basic_prod c=%0d got %0d exp %0d", c, prod2, exp_p[c-3]);
                end
                n_vec++;
                if ({ai2, bj2, ak2, bk2} !== exp_idx[c-3]) begin
                    n_err++; $display("FAIL basic_idx c=%0d got %b exp %b", c, {ai2, bj2, ak2, bk2}, exp_idx[c-3]);
                end
            end
            n_vec++;
            if (done2 !== (c == 11)) begin
                n_err++; $display("FAIL basic_done c=%0d got %b exp %b", c, done2, (c == 11));
            end
            n_vec++;
            if (busy2 !== (c <= 11)) begin
                n_err++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy2, (c <= 11));
            end
            n_vec++;
            if ({are2, bre2} !== {2{c <= 8}}) begin
                n_err++; $display("FAIL basic_re c=%0d got %b exp %b", c, {are2, bre2}, {2{c <= 8}});
            end
            tick();
        end
    endtask

    task automatic test_max_operands();
        int nv;
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++) begin
                A2[r][q] = 32'hFFFF_FFFF;
                B2[r][q] = 32'hFFFF_FFFF;
            end
        nv = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (mdone2 === 1'b1) begin
                nv++;
                n_vec++;
                if (prod2 !== 64'hFFFF_FFFE_0000_0001) begin
                    n_err++; $display("FAIL max_prod c=%0d got %h exp fffffffe00000001", c, prod2);
                end
            end
            n_vec++;
            if (done2 !== (c == 11)) begin
                n_err++; $display("FAIL max_done c=%0d got %b exp %b", c, done2, (c == 11));
            end
            tick();
        end
        n_vec++;
        if (nv != 8) begin
            n_err++; $display("FAIL max_count got %0d exp 8", nv);
        end
    endtask

    task automatic test_back_to_back();
        logic e_v;
        int   p;
        load_basic();
        start2 = 1'b1;
        tick();
        for (int c = 1; c <= 23; c++) begin
            e_v = (c >= 3 && c <= 10) || (c >= 15 && c <= 22);
            n_vec++;
            if (mdone2 !== e_v) begin
                n_err++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, mdone2, e_v);
            end
            if (e_v) begin
                p = (c <= 10) ? c - 3 : c - 15;
                n_vec++;
                if (prod2 !== exp_p[p] || {ai2, bj2, ak2, bk2} !== exp_idx[p]) begin
                    n_err++; $display("FAIL b2b_data c=%0d got %0d/%b exp %0d/%b", c, prod2, {ai2, bj2, ak2, bk2}, exp_p[p], exp_idx[p]);
                end
            end
            n_vec++;
            if (done2 !== (c == 11 || c == 23)) begin
                n_err++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done2, (c == 11 || c == 23));
            end
            tick();
        end
        start2 = 1'b0;
        n_vec++;
        if (busy2 !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle got %b exp 0", busy2);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        int ei, ej, ek, nv;
        logic [63:0] ep;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                A4[r][q] = $urandom;
                B4[r][q] = $urandom;
            end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        rstn4 = 1'b0;
        #1;
        n_vec++;
        if ({busy4, done4, are4, bre4, mdone4} !== 5'b0 || prod4 !== 64'd0 ||
            {ai4, bj4, ak4, bk4, arow4, acol4, brow4, bcol4} !== 16'd0) begin
            n_err++; $display("FAIL midrst_zero got ctrl=%b prod=%h idx=%h exp all 0",
                              {busy4, done4, are4, bre4, mdone4}, prod4, {ai4, bj4, ak4, bk4});
        end
        tick(); tick();
        rstn4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if ({busy4, done4, mdone4} !== 3'b0) begin
                n_err++; $display("FAIL midrst_quiet c=%0d got %b exp 000", c, {busy4, done4, mdone4});
            end
            tick();
        end
        nv = 0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            n_vec++;
            if ({are4, bre4} !== {2{c <= 64}}) begin
                n_err++; $display("FAIL rerun_re c=%0d got %b exp %b", c, {are4, bre4}, {2{c <= 64}});
            end
            n_vec++;
            if (mdone4 !== (c >= 3 && c <= 66)) begin
                n_err++; $display("FAIL rerun_valid c=%0d got %b exp %b", c, mdone4, (c >= 3 && c <= 66));
            end
            if (mdone4 === 1'b1) begin
                ei = nv / 16; ej = (nv / 4) % 4; ek = nv % 4;
                ep = 64'(A4[ei][ek]) * 64'(B4[ek][ej]);
                n_vec++;
                if ({ai4, bj4, ak4, bk4} !== {2'(ei), 2'(ej), 2'(ek), 2'(ek)}) begin
                    n_err++; $display("FAIL rerun_idx n=%0d got %b exp %0d,%0d,%0d", nv, {ai4, bj4, ak4, bk4}, ei, ej, ek);
                end
                n_vec++;
                if (prod4 !== ep) begin
                    n_err++; $display("FAIL rerun_prod n=%0d got %h exp %h", nv, prod4, ep);
                end
                nv++;
            end
            n_vec++;
            if (done4 !== (c == 67)) begin
                n_err++; $display("FAIL rerun_done c=%0d got %b exp %b", c, done4, (c == 67));
            end
            tick();
        end
        n_vec++;
        if (nv != 64) begin
            n_err++; $display("FAIL rerun_count got %0d exp 64", nv);
        end
    endtask

    task automatic test_nonpow2();
        int ei, ej, ek, nv;
        logic [63:0] ep;
        for (int r = 0; r < 3; r++) begin
            for (int q = 0; q < 3; q++) A3[r][q] = $urandom;
            for (int q = 0; q < 2; q++) B3[r][q] = $urandom;
        end
        nv = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            n_vec++;
            if ({are3, bre3} !== {2{c <= 18}}) begin
                n_err++; $display("FAIL np2_re c=%0d got %b exp %b", c, {are3, bre3}, {2{c <= 18}});
            end
            n_vec++;
            if (mdone3 !== (c >= 3 && c <= 20)) begin
                n_err++; $display("FAIL np2_valid c=%0d got %b exp %b", c, mdone3, (c >= 3 && c <= 20));
            end
            if (mdone3 === 1'b1) begin
                ei = nv / 6; ej = (nv / 3) % 2; ek = nv % 3;
                ep = 64'(A3[ei][ek]) * 64'(B3[ek][ej]);
                n_vec++;
                if ({ai3, bj3, ak3, bk3} !== {2'(ei), 1'(ej), 2'(ek), 2'(ek)}) begin
                    n_err++; $display("FAIL np2_idx n=%0d got %b exp %0d,%0d,%0d", nv, {ai3, bj3, ak3, bk3}, ei, ej, ek);
                end
                n_vec++;
                if (prod3 !== ep) begin
                    n_err++; $display("FAIL np2_prod n=%0d got %h exp %h", nv, prod3, ep);
                end
                nv++;
            end
            n_vec++;
            if (done3 !== (c == 21)) begin
                n_err++; $display("FAIL np2_done c=%0d got %b exp %b", c, done3, (c == 21));
            end
            tick();
        end
        n_vec++;
        if (nv != 18) begin
            n_err++; $display("FAIL np2_count got %0d exp 18", nv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_p   = '{64'd5, 64'd14, 64'd6, 64'd16, 64'd15, 64'd28, 64'd18, 64'd32};
        exp_idx = '{4'b0000, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b1100, 4'b1111};
        test_reset();
        test_basic();
        test_max_operands();
        test_back_to_back();
        test_reset_midrun();
        test_nonpow2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_operand_fetch_mult.md
# matmul_operand_fetch_mult

Upstream operand stage of the matrix-multiply datapath. On `start` it walks the A (M×K) and B (K×N) operand memories in row-of-C order and issues one synchronous read pair per cycle. It multiplies each returned pair and presents a registered product, with the loop indices aligned to it and a valid strobe. The output bundle feeds the MAC/accumulate stage directly, which consumes one product per cycle with no back-pressure.

## Interface
Parameters:
- `M`, 4, rows of A and C (≥2)
- `K`, 4, cols of A / rows of B (≥2)
- `N`, 4, cols of B and C (≥2)
- `DATA_WIDTH_INIT_MATRIX`, 32, operand width (unsigned)

Ports:
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a multiply; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse after last product is presented
- `matrix_a_re`  out  1  A read enable
- `matrix_a_row_addr`  out  $clog2(M)  A row index i
- `matrix_a_col_addr`  out  $clog2(K)  A col index k
- `data_in_a`  in  DATA_WIDTH_INIT_MATRIX  A read data, valid 1 cycle after `matrix_a_re`
- `matrix_b_re`  out  1  B read enable
- `matrix_b_row_addr`  out  $clog2(K)  B row index k
- `matrix_b_col_addr`  out  $clog2(N)  B col index j
- `data_in_b`  in  DATA_WIDTH_INIT_MATRIX  B read data, valid 1 cycle after `matrix_b_re`
- `product_reg`  out  2*DATA_WIDTH_INIT_MATRIX  registered A[i][k]*B[k][j]
- `matrix_a_col_addr_counter_reg`  out  $clog2(K)  k aligned to `product_reg`
- `matrix_a_row_addr_counter_reg`  out  $clog2(M)  i aligned
- `matrix_b_col_addr_counter_reg`  out  $clog2(N)  j aligned
- `matrix_b_row_addr_counter_reg`  out  $clog2(K)  k aligned
- `mult_done_reg`  out  1  `product_reg` and aligned indices valid this cycle

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last issue (i=M-1, j=N-1, k=K-1).
  - DRAIN → DONE after 2 cycles.
  - DONE → IDLE after 1 cycle.
- `start` is ignored outside IDLE. It is also ignored in DONE; a new `start` is accepted on the following IDLE cycle.
- Loop order: k innermost, then j, then i. Issue sequence: (i,j,k) = (0,0,0),(0,0,1)…(0,0,K-1),(0,1,0)…(M-1,N-1,K-1). Total T = M·N·K issues, one per RUN cycle, no gaps.
- A and B read addresses are issued together. `matrix_a_re` and `matrix_b_re` are both high in every RUN cycle and low in all other states.
- Stage 1 (issue): addresses and a valid bit plus index copies are registered. Stage 2 (memory returns data): the index/valid pipeline is delayed one more cycle.
- Stage 3: `product_reg <= data_in_a * data_in_b`. Full 2W-bit unsigned product, no truncation. Index outputs and `mult_done_reg` update on the same edge from the delayed copies.
- When `mult_done_reg`=0, `product_reg` and the index outputs hold their last values.
- Index counters wrap to 0 at their maximum. Non-power-of-two M/K/N must wrap at M-1/K-1/N-1, not at 2^width-1.
- Reset values: all outputs 0, state IDLE, all internal valid bits 0.
- Reset asserted mid-operation aborts immediately. No further `mult_done_reg` or `done` is produced for that run, and the next `start` begins at (0,0,0).

## Timing
- `start` sampled high in IDLE at edge 0. RUN spans cycles 1..T, with addresses for issue n (1-based) driven in cycle n.
- Read data for issue n is present in cycle n+1. `product_reg`/`mult_done_reg` for issue n are valid in cycle n+2.
- `mult_done_reg` is high for exactly T consecutive cycles, 3..T+2.
- DRAIN occupies cycles T+1, T+2. `done`=1 only in cycle T+3 (DONE state). `busy`=1 in cycles 1..T+3.
- Indices with k=K-1 appear on `matrix_b_row_addr_counter_reg` exactly every K-th valid cycle. The downstream write-back relies on this.
- `done` and all product/index outputs are registered; there is no combinational path from inputs to outputs.
- Earliest back-to-back run: `start` in cycle T+4 puts RUN in cycle T+5.

## Test plan
- M=K=N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], `start` at cycle 0. Required `product_reg` sequence, cycles 3..10: 5,14,6,16,15,28,18,32. Required (i,j,k) sequence: (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…. Required `done` only at cycle 11.
- All operands 0xFFFFFFFF (W=32) → every `product_reg` = 0xFFFFFFFE00000001, with no truncation.
- `start` held high continuously → `start` is ignored during RUN/DRAIN/DONE. A second run begins after IDLE with identical output. `mult_done_reg` shows exactly T highs per run, with one idle gap cycle.
- `resetn` pulsed low at cycle 5 of a 4×4×4 run → all outputs 0 immediately, no `done`. A subsequent `start` restarts at indices (0,0,0) and produces all 64 products.
- M=3, K=3, N=2 (non-power-of-two): indices wrap at 2/2/1. 18 valid products are produced, and `done` occurs at cycle 21.
- Memory models return random data: a scoreboard checks every `product_reg` against A[i][k]*B[k][j] using the aligned indices, and checks that `matrix_*_re` are low outside RUN.
